counter_updown_mod: RTL and testbench

Parametrised up/down modulo counter that generalises the fixed 4-bit free-running reset counter. It adds:
- configurable width and reset value;
- count enable, direction and parallel load;
- a runtime modulus (inclusive upper limit);
- wrap or saturate mode;
- registered wrap pulse and sticky overflow flag.

It is the standard event/timebase counter used by sequencing and timeout logic across the design.

---
 rtl/counter_updown_mod.sv | 96 +++++++++
 tb/tb_counter_updown_mod.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/counter_updown_mod.sv
// ----------------------------------------------------------------------------
// counter_updown_mod
//   Parametrised up/down modulo counter used as the common event/timebase
//   counter for sequencing and timeout logic. Counts in [0, limit_i], where
//   limit_i can change at run time. At the terminal count it either wraps
//   around or saturates (SATURATE). It reports a registered one-cycle wrap
//   pulse and a sticky overflow flag.
//
// Parameters
//   WIDTH    : counter width in bits (>= 2)
//   INIT     : count value after reset
//   SATURATE : 0 = wrap at terminal count, 1 = hold at terminal count
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous reset, active low
//   en_i       : count enable, one step per cycle while high
//   dir_i      : 1 = count up, 0 = count down
//   load_i     : parallel load strobe (wins over en_i)
//   load_val_i : value loaded on load_i (not clamped to limit_i)
//   limit_i    : inclusive upper bound of the count range
//   count_o    : registered current count
//   wrap_o     : registered pulse, terminal event on the previous edge
//   ovf_o      : sticky, terminal event since the last reset/load
//   zero_o     : combinational, count_o == 0
//   at_max_o   : combinational, count_o >= limit_i
// ----------------------------------------------------------------------------
module counter_updown_mod #(
    parameter int unsigned      WIDTH    = 4,
    parameter logic [WIDTH-1:0] INIT     = '0,
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic             at_max_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q,  wrap_d;
    logic             ovf_q,   ovf_d;
    logic             term;

    // Up: any count at or above limit is terminal, so an out-of-range value
    // (from a load or a limit that shrank) folds back in on the next step.
    // Down: only zero is terminal; a count above limit steps down normally.
    assign term = dir_i ? (count_q >= limit_i) : (count_q == '0);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (load_i) begin
            count_d = load_val_i;
            ovf_d   = 1'b0;
        end else if (en_i) begin
            if (term) begin
                wrap_d = 1'b1;
                ovf_d  = 1'b1;
                if (dir_i) count_d = SATURATE ? limit_i : '0;
                else       count_d = SATURATE ? '0      : limit_i;
            end else begin
                count_d = dir_i ? count_q + ONE : count_q - ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= INIT;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o  = count_q;
    assign wrap_o   = wrap_q;
    assign ovf_o    = ovf_q;
    assign zero_o   = (count_q == '0);
    assign at_max_o = (count_q >= limit_i);

endmodule

// File: tb/tb_counter_updown_mod.sv
// ----------------------------------------------------------------------------
// tb_counter_updown_mod
//   Directed bench for counter_updown_mod. Two instances share all inputs:
//   one in wrap mode, one in saturate mode, both WIDTH=4, INIT=5. Expected
//   values are hand-computed from the counter's documented behaviour.
// ----------------------------------------------------------------------------
module tb_counter_updown_mod;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, dir, load;
    logic [3:0] load_val, limit;

    logic [3:0] w_count, s_count;
    logic       w_wrap, s_wrap, w_ovf, s_ovf, w_zero, s_zero, w_atmax, s_atmax;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    counter_updown_mod #(.WIDTH(4), .INIT(4'd5), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en_i(en), .dir_i(dir), .load_i(load),
        .load_val_i(load_val), .limit_i(limit),
        .count_o(w_count), .wrap_o(w_wrap), .ovf_o(w_ovf),
        .zero_o(w_zero), .at_max_o(w_atmax)
    );

    counter_updown_mod #(.WIDTH(4), .INIT(4'd5), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en_i(en), .dir_i(dir), .load_i(load),
        .load_val_i(load_val), .limit_i(limit),
        .count_o(s_count), .wrap_o(s_wrap), .ovf_o(s_ovf),
        .zero_o(s_zero), .at_max_o(s_atmax)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One rising edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ew, es;
        rst = 1'b0; en = 1'b0; dir = 1'b1; load = 1'b0;
        load_val = 4'd0; limit = 4'd9;

        // Reset for two cycles
        step(); step();
        chk("rst w_count", w_count, 5);
        chk("rst s_count", s_count, 5);
        chk("rst w_wrap",  w_wrap,  0);
        chk("rst w_ovf",   w_ovf,   0);
        chk("rst s_ovf",   s_ovf,   0);
        chk("rst zero",    w_zero,  0);
        chk("rst at_max",  w_atmax, 0);

        // Release with en low: hold
        rst = 1'b1;
        step();
        chk("hold w_count", w_count, 5);
        chk("hold s_count", s_count, 5);

        // Up count with limit 9
        load = 1'b1; load_val = 4'd0;
        step();
        chk("ld0 w_count", w_count, 0);
        chk("ld0 zero",    w_zero,  1);
        load = 1'b0; en = 1'b1; dir = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            ew = (i <= 9) ? i : i - 10;
            es = (i <= 9) ? i : 9;
            chk($sformatf("up%0d w_count", i), w_count, ew);
            chk($sformatf("up%0d w_wrap", i),  w_wrap,  (i == 10) ? 1 : 0);
            chk($sformatf("up%0d w_ovf", i),   w_ovf,   (i >= 10) ? 1 : 0);
            chk($sformatf("up%0d s_count", i), s_count, es);
            chk($sformatf("up%0d s_wrap", i),  s_wrap,  (i >= 10) ? 1 : 0);
            chk($sformatf("up%0d s_atmax", i), s_atmax, (i >= 9) ? 1 : 0);
        end

        // Down count with limit 6 from 1
        limit = 4'd6; load = 1'b1; load_val = 4'd1;
        step();
        chk("ld1 w_ovf",   w_ovf,   0);
        chk("ld1 s_count", s_count, 1);
        load = 1'b0; dir = 1'b0;
        step();
        chk("dn1 w_count", w_count, 0);
        chk("dn1 w_wrap",  w_wrap,  0);
        chk("dn1 s_count", s_count, 0);
        step();
        chk("dn2 w_count", w_count, 6);
        chk("dn2 w_wrap",  w_wrap,  1);
        chk("dn2 w_ovf",   w_ovf,   1);
        chk("dn2 s_count", s_count, 0);
        chk("dn2 s_wrap",  s_wrap,  1);
        step();
        chk("dn3 w_count", w_count, 5);
        chk("dn3 w_wrap",  w_wrap,  0);
        chk("dn3 s_count", s_count, 0);
        chk("dn3 s_wrap",  s_wrap,  1);
        chk("dn3 s_ovf",   s_ovf,   1);

        // Out-of-range load, then up one step
        limit = 4'd3; load = 1'b1; load_val = 4'd12;
        step();
        chk("oor w_count", w_count, 12);
        chk("oor w_atmax", w_atmax, 1);
        chk("oor w_ovf",   w_ovf,   0);
        load = 1'b0; dir = 1'b1;
        step();
        chk("oor up w_count", w_count, 0);
        chk("oor up s_count", s_count, 3);
        chk("oor up w_wrap",  w_wrap,  1);
        chk("oor up s_ovf",   s_ovf,   1);

        // Load right after a terminal event: wrap drops, ovf clears
        load = 1'b1;
        step();
        chk("reld w_count", w_count, 12);
        chk("reld w_wrap",  w_wrap,  0);
        chk("reld w_ovf",   w_ovf,   0);
        load = 1'b0; dir = 1'b0;
        step();
        chk("oor dn w_count", w_count, 11);
        chk("oor dn s_count", s_count, 11);
        chk("oor dn w_wrap",  w_wrap,  0);

        // Priority: rst over load and en
        rst = 1'b0; load = 1'b1; en = 1'b1; load_val = 4'd7; dir = 1'b1;
        step();
        chk("pri rst w_count", w_count, 5);
        chk("pri rst s_count", s_count, 5);
        rst = 1'b1;
        step();
        chk("pri ld w_count", w_count, 7);
        chk("pri ld w_ovf",   w_ovf,   0);
        load_val = 4'd8;
        step();
        chk("b2b ld w_count", w_count, 8);

        // Runtime limit change while counting up
        load = 1'b0; limit = 4'd15;
        #1;
        chk("lim15 at_max", w_atmax, 0);
        limit = 4'd4;
        #1;
        chk("lim4 at_max comb", w_atmax, 1);
        step();
        chk("lim4 w_count", w_count, 0);
        chk("lim4 w_wrap",  w_wrap,  1);
        chk("lim4 w_atmax", w_atmax, 0);
        chk("lim4 s_count", s_count, 4);
        chk("lim4 s_atmax", s_atmax, 1);

        // en low: hold count and ovf, wrap clears
        en = 1'b0;
        step();
        chk("idle w_count", w_count, 0);
        chk("idle w_wrap",  w_wrap,  0);
        chk("idle w_ovf",   w_ovf,   1);
        chk("idle s_count", s_count, 4);

        // limit = 0: pinned at 0, wrap every enabled cycle
        limit = 4'd0; load = 1'b1; load_val = 4'd0;
        step();
        load = 1'b0; en = 1'b1; dir = 1'b1;
        step();
        chk("l0 up1 w_count", w_count, 0);
        chk("l0 up1 w_wrap",  w_wrap,  1);
        step();
        chk("l0 up2 w_wrap",  w_wrap,  1);
        chk("l0 up2 s_count", s_count, 0);
        dir = 1'b0;
        step();
        chk("l0 dn w_count", w_count, 0);
        chk("l0 dn w_wrap",  w_wrap,  1);
        chk("l0 dn s_wrap",  s_wrap,  1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
